fix_serializer: RTL and testbench

- Transmit-side counterpart of the FIX tag/value parser: turns a sequence of fields (binary tag number plus value byte stream) into a FIX byte stream "tag=value<SOH>".
- Optionally closes each message with a standard checksum trailer "10=ddd<SOH>".
- Sits between the order-generation logic and the byte-wide line/MAC interface.
- Single output register with valid/ready backpressure.

---
 rtl/fix_serializer.sv | 211 +++++++++++++++++++++
 tb/tb_fix_serializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_serializer.sv
// FIX field serializer: binary tag + value byte stream -> "tag=value<SOH>",
// optionally followed by a "10=ddd<SOH>" checksum trailer on the last field.
module fix_serializer #(
   parameter int unsigned TAG_W    = 16,
   parameter logic [7:0]  SOH_C    = 8'h01,
   parameter logic [7:0]  SEP_C    = 8'h3D,
   parameter bit          CKSUM_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fld_valid_i,
   output logic             fld_ready_o,
   input  logic [TAG_W-1:0] fld_tag_i,
   input  logic             fld_last_i,
   input  logic             val_valid_i,
   output logic             val_ready_o,
   input  logic [7:0]       val_data_i,
   input  logic             val_last_i,
   output logic [7:0]       data_o,
   output logic             data_valid_o,
   input  logic             data_ready_i,
   output logic             soh_o,
   output logic             msg_end_o,
   output logic             busy_o
);

   // Decimal digits needed for TAG_W bits (log10(2) ~ 0.301).
   localparam int unsigned ND = (TAG_W * 301) / 1000 + 1;
   localparam int unsigned BW = ND * 4;
   localparam int unsigned DW = (ND > 1) ? $clog2(ND) : 1;
   localparam int unsigned CW = $clog2(TAG_W + 1);

   typedef enum logic [2:0] {StIdle, StConv, StTag, StSep, StValue, StFsoh, StCk} state_e;

   state_e           state_q, state_d;
   logic [TAG_W-1:0] bin_q, bin_d, step_bin;
   logic [BW-1:0]    bcd_q, bcd_d, step_bcd, adj_bcd;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    dig_q, dig_d, msd;
   logic [2:0]       ck_idx_q, ck_idx_d;
   logic [7:0]       sum_q, sum_d, ck_q, ck_d;
   logic [7:0]       data_q, data_d, byte_n;
   logic             last_q, last_d;
   logic             dv_q, dv_d, soh_q, soh_d, end_q, end_d;
   logic             emit, soh_n, end_n, out_free;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         dig_q    <= '0;
         ck_idx_q <= '0;
         sum_q    <= '0;
         ck_q     <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         dv_q     <= 1'b0;
         soh_q    <= 1'b0;
         end_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         dig_q    <= dig_d;
         ck_idx_q <= ck_idx_d;
         sum_q    <= sum_d;
         ck_q     <= ck_d;
         data_q   <= data_d;
         last_q   <= last_d;
         dv_q     <= dv_d;
         soh_q    <= soh_d;
         end_q    <= end_d;
      end
   end

   // One double-dabble step: add-3 on nibbles >= 5, then shift left.
   always_comb begin
      adj_bcd = bcd_q;
      for (int i = 0; i < ND; i++) begin
         if (adj_bcd[4*i +: 4] >= 4'd5) adj_bcd[4*i +: 4] = adj_bcd[4*i +: 4] + 4'd3;
      end
      {step_bcd, step_bin} = {adj_bcd[BW-2:0], bin_q, 1'b0};
      msd = '0;
      for (int i = 0; i < ND; i++) begin
         if (step_bcd[4*i +: 4] != 4'd0) msd = DW'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      dig_d       = dig_q;
      ck_idx_d    = ck_idx_q;
      sum_d       = sum_q;
      ck_d        = ck_q;
      last_d      = last_q;
      data_d      = data_q;
      dv_d        = dv_q;
      soh_d       = soh_q;
      end_d       = end_q;
      emit        = 1'b0;
      byte_n      = 8'h00;
      soh_n       = 1'b0;
      end_n       = 1'b0;
      fld_ready_o = 1'b0;
      val_ready_o = 1'b0;
      out_free    = !dv_q || data_ready_i;

      unique case (state_q)
         StIdle: begin
            fld_ready_o = 1'b1;
            if (fld_valid_i) begin
               bin_d   = fld_tag_i;
               bcd_d   = '0;
               cnt_d   = '0;
               last_d  = fld_last_i;
               state_d = StConv;
            end
         end
         StConv: begin
            bcd_d = step_bcd;
            bin_d = step_bin;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(TAG_W - 1)) begin
               dig_d   = msd;
               state_d = StTag;
            end
         end
         StTag: begin
            emit   = 1'b1;
            byte_n = 8'h30 + {4'h0, bcd_q[4*dig_q +: 4]};
            if (out_free) begin
               if (dig_q == '0) state_d = StSep;
               else dig_d = dig_q - 1'b1;
            end
         end
         StSep: begin
            emit   = 1'b1;
            byte_n = SEP_C;
            if (out_free) state_d = StValue;
         end
         StValue: begin
            val_ready_o = out_free;
            emit        = val_valid_i;
            byte_n      = val_data_i;
            if (val_valid_i && out_free && val_last_i) state_d = StFsoh;
         end
         StFsoh: begin
            emit   = 1'b1;
            byte_n = SOH_C;
            soh_n  = 1'b1;
            if (out_free) begin
               if (last_q && CKSUM_EN) begin
                  ck_d     = sum_q + SOH_C;
                  ck_idx_d = '0;
                  state_d  = StCk;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StCk: begin
            emit = 1'b1;
            case (ck_idx_q)
               3'd0:    byte_n = 8'h31;
               3'd1:    byte_n = 8'h30;
               3'd2:    byte_n = 8'h3D;
               3'd3:    byte_n = 8'h30 + (ck_q / 8'd100);
               3'd4:    byte_n = 8'h30 + ((ck_q / 8'd10) % 8'd10);
               3'd5:    byte_n = 8'h30 + (ck_q % 8'd10);
               default: begin
                  byte_n = SOH_C;
                  soh_n  = 1'b1;
                  end_n  = 1'b1;
               end
            endcase
            if (out_free) begin
               ck_idx_d = ck_idx_q + 1'b1;
               if (ck_idx_q == 3'd6) begin
                  sum_d   = '0;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Trailer bytes never feed the running checksum.
      if (emit && out_free) begin
         data_d = byte_n;
         soh_d  = soh_n;
         end_d  = end_n;
         dv_d   = 1'b1;
         if (state_q != StCk) sum_d = sum_q + byte_n;
      end else if (data_ready_i) begin
         dv_d = 1'b0;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = dv_q;
   assign soh_o        = soh_q;
   assign msg_end_o    = end_q;
   assign busy_o       = (state_q != StIdle) || dv_q;

endmodule

// File: tb/tb_fix_serializer.sv
// Scoreboard bench for fix_serializer: instance 0 with checksum trailer,
// instance 1 with CKSUM_EN=0.
module tb_fix_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        data_ready = 1'b1;
   logic        fld_valid [2];
   logic [15:0] fld_tag [2];
   logic        fld_last [2];
   logic        val_valid [2];
   logic [7:0]  val_data [2];
   logic        val_last [2];
   logic        fld_ready [2];
   logic        val_ready [2];
   logic [7:0]  data [2];
   logic        data_valid [2];
   logic        soh [2];
   logic        msg_end [2];
   logic        busy [2];

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   logic [9:0]  q0[$];
   logic [9:0]  q1[$];
   byte unsigned sum0 = 0;
   byte unsigned sum1 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fix_serializer #(.CKSUM_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .fld_valid_i(fld_valid[0]), .fld_ready_o(fld_ready[0]), .fld_tag_i(fld_tag[0]),
      .fld_last_i(fld_last[0]), .val_valid_i(val_valid[0]), .val_ready_o(val_ready[0]),
      .val_data_i(val_data[0]), .val_last_i(val_last[0]), .data_o(data[0]),
      .data_valid_o(data_valid[0]), .data_ready_i(data_ready), .soh_o(soh[0]),
      .msg_end_o(msg_end[0]), .busy_o(busy[0])
   );

   fix_serializer #(.CKSUM_EN(1'b0)) dut_nock (
      .clk(clk), .rst(rst),
      .fld_valid_i(fld_valid[1]), .fld_ready_o(fld_ready[1]), .fld_tag_i(fld_tag[1]),
      .fld_last_i(fld_last[1]), .val_valid_i(val_valid[1]), .val_ready_o(val_ready[1]),
      .val_data_i(val_data[1]), .val_last_i(val_last[1]), .data_o(data[1]),
      .data_valid_o(data_valid[1]), .data_ready_i(data_ready), .soh_o(soh[1]),
      .msg_end_o(msg_end[1]), .busy_o(busy[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Outputs sampled on the falling edge; a handshake here completes at the next rise.
   always @(negedge clk) begin
      if (!rst && data_valid[0] && data_ready) begin
         if (q0.size() == 0) check_eq("unexpected_byte0", {msg_end[0], soh[0], data[0]}, 10'h3FF);
         else check_eq("byte0", {msg_end[0], soh[0], data[0]}, q0.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!rst && data_valid[1] && data_ready) begin
         if (q1.size() == 0) check_eq("unexpected_byte1", {msg_end[1], soh[1], data[1]}, 10'h3FF);
         else check_eq("byte1", {msg_end[1], soh[1], data[1]}, q1.pop_front());
      end
   end

   function automatic void push_b(input int d, input logic [9:0] e, input bit acc);
      if (d == 0) begin
         q0.push_back(e);
         if (acc) sum0 = sum0 + e[7:0];
      end else begin
         q1.push_back(e);
         if (acc) sum1 = sum1 + e[7:0];
      end
   endfunction

   function automatic void push_field(input int d, input int unsigned tag, input string v,
                                      input bit last, input bit cken);
      string t;
      int    s;
      t = $sformatf("%0d", tag);
      for (int i = 0; i < t.len(); i++) push_b(d, {2'b00, t[i]}, 1'b1);
      push_b(d, 10'h03D, 1'b1);
      for (int i = 0; i < v.len(); i++) push_b(d, {2'b00, v[i]}, 1'b1);
      push_b(d, 10'h101, 1'b1);
      if (last && cken) begin
         s = (d == 0) ? int'(sum0) : int'(sum1);
         push_b(d, 10'h031, 1'b0);
         push_b(d, 10'h030, 1'b0);
         push_b(d, 10'h03D, 1'b0);
         push_b(d, {2'b00, 8'(8'h30 + s / 100)}, 1'b0);
         push_b(d, {2'b00, 8'(8'h30 + (s / 10) % 10)}, 1'b0);
         push_b(d, {2'b00, 8'(8'h30 + s % 10)}, 1'b0);
         push_b(d, 10'h301, 1'b0);
         if (d == 0) sum0 = 0;
         else sum1 = 0;
      end
   endfunction

   task automatic send_hdr(input int d, input logic [15:0] tag, input bit last);
      bit ok = 1'b0;
      fld_valid[d] = 1'b1;
      fld_tag[d]   = tag;
      fld_last[d]  = last;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (fld_ready[d]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("hdr_timeout", {31'd0, fld_ready[d]}, 32'd1);
      @(posedge clk);
      #1;
      fld_valid[d] = 1'b0;
      acc_cyc      = cyc;
   endtask

   task automatic send_val(input int d, input string v, input bit last);
      for (int i = 0; i < v.len(); i++) begin
         bit ok = 1'b0;
         val_valid[d] = 1'b1;
         val_data[d]  = v[i];
         val_last[d]  = last && (i == v.len() - 1);
         for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (val_ready[d]) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) check_eq("val_timeout", {31'd0, val_ready[d]}, 32'd1);
         @(posedge clk);
         #1;
      end
      val_valid[d] = 1'b0;
      val_last[d]  = 1'b0;
   endtask

   task automatic send_field(input int d, input int unsigned tag, input string v,
                             input bit last, input bit cken);
      push_field(d, tag, v, last, cken);
      send_hdr(d, 16'(tag), last);
      send_val(d, v, 1'b1);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         fld_valid[d] = 1'b0;
         fld_tag[d]   = '0;
         fld_last[d]  = 1'b0;
         val_valid[d] = 1'b0;
         val_data[d]  = '0;
         val_last[d]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_eq("rst_valid", {31'd0, data_valid[0]}, 32'd0);
      check_eq("rst_data", {24'd0, data[0]}, 32'd0);
      check_eq("rst_fld_ready", {31'd0, fld_ready[0]}, 32'd1);
      check_eq("rst_val_ready", {31'd0, val_ready[0]}, 32'd0);
      check_eq("rst_busy", {31'd0, busy[0]}, 32'd0);
      check_eq("rst_flags", {30'd0, soh[0], msg_end[0]}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // "35=A^10=231^" with first-digit latency check.
      push_field(0, 35, "A", 1'b1, 1'b1);
      send_hdr(0, 16'd35, 1'b1);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (data_valid[0]) break;
      end
      check_eq("latency", cyc - acc_cyc, 32'd17);
      check_eq("first_digit", {24'd0, data[0]}, 32'h33);
      send_val(0, "A", 1'b1);

      // Tag boundaries, no trailer; checksum keeps accumulating.
      send_field(0, 0, "X", 1'b0, 1'b1);
      send_field(0, 8, "X", 1'b0, 1'b1);
      send_field(0, 65535, "X", 1'b0, 1'b1);

      // Backpressure on '.' while the value streams.
      push_field(0, 1, "FIX.4.2", 1'b1, 1'b1);
      fork
         begin
            send_hdr(0, 16'd1, 1'b1);
            send_val(0, "FIX.4.2", 1'b1);
         end
         begin
            bit seen = 1'b0;
            for (int n = 0; n < 200; n++) begin
               @(posedge clk);
               #1;
               if (data_valid[0] && data[0] == 8'h2E) begin
                  seen = 1'b1;
                  break;
               end
            end
            check_eq("stall_seen", {31'd0, seen}, 32'd1);
            data_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check_eq("stall_hold", {23'd0, data_valid[0], data[0]}, 32'h12E);
               check_eq("stall_vrdy", {31'd0, val_ready[0]}, 32'd0);
               @(posedge clk);
               #1;
            end
            data_ready = 1'b1;
         end
      join

      // Byte sum > 255, then a fresh message whose checksum starts at 0.
      send_field(0, 49, "ABCDEFG", 1'b1, 1'b1);
      send_field(0, 35, "A", 1'b1, 1'b1);

      // Asynchronous reset in the middle of a value.
      push_b(0, 10'h033, 1'b1);
      push_b(0, 10'h035, 1'b1);
      push_b(0, 10'h03D, 1'b1);
      send_hdr(0, 16'd35, 1'b1);
      send_val(0, "A", 1'b0);
      data_ready = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_valid", {31'd0, data_valid[0]}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_valid", {31'd0, data_valid[0]}, 32'd0);
      check_eq("async_rst_fld_ready", {31'd0, fld_ready[0]}, 32'd1);
      check_eq("async_rst_busy", {31'd0, busy[0]}, 32'd0);
      check_eq("rst_q_drained", q0.size(), 32'd0);
      q0.delete();
      sum0 = 0;
      @(negedge clk);
      rst        = 1'b0;
      data_ready = 1'b1;
      @(posedge clk);
      #1;
      send_field(0, 35, "A", 1'b1, 1'b1);

      // No trailer when checksum is disabled, even on the last field.
      send_field(1, 35, "A", 1'b1, 1'b0);

      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && !busy[0] && !busy[1]) break;
      end
      check_eq("q0_empty", q0.size(), 32'd0);
      check_eq("q1_empty", q1.size(), 32'd0);
      check_eq("end_idle0", {30'd0, fld_ready[0], busy[0]}, 32'd2);
      check_eq("end_idle1", {30'd0, fld_ready[1], busy[1]}, 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
